// File: rtl/spawn_scheduler_pkg.sv
// Spawn scheduler shared types: FSM state encoding,
// the NONE type code and default geometry constants.
package spawn_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SPAWN,
    S_UPDATE,
    S_SETTLE,
    S_RETIRE,
    S_HALT
  } state_e;

  localparam int TYPE_NONE  = 0;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_VIEW_W = 640;

endpackage

// File: rtl/spawn_type_picker.sv
// Combinational spawn-type choice: walks rng-rotated candidates.
// Ports: rng/speed/min_speed in, recent types + dup_chk in,
// valid/type_o out (type_o is NONE when nothing qualifies).
module spawn_type_picker
  import spawn_scheduler_pkg::*;
#(
  parameter int  N_TYPES = 3,
  parameter int  MAX_DUP = 2,
  localparam int TYPE_W  = $clog2(N_TYPES + 1)
) (
  input  logic [10:0]                    rng,
  input  logic [14:0]                    speed,
  input  logic [N_TYPES:1][14:0]         min_speed,
  input  logic [MAX_DUP-1:0][TYPE_W-1:0] recent,
  input  logic                           dup_chk,
  output logic                           valid,
  output logic [TYPE_W-1:0]              type_o
);

  logic [TYPE_W-1:0] c;
  logic              dup;
  logic              ok;

  always_comb begin
    valid  = 1'b0;
    type_o = TYPE_W'(TYPE_NONE);
    c      = '0;
    dup    = 1'b0;
    ok     = 1'b0;
    for (int i = 0; i < N_TYPES; i++) begin
      c   = TYPE_W'((32'(rng) + 32'(i)) % N_TYPES + 1);
      // run-length limit only bites once MAX_DUP live entries exist
      dup = dup_chk;
      for (int k = 0; k < MAX_DUP; k++) begin
        if (recent[k] != c) dup = 1'b0;
      end
      ok = (speed >= min_speed[c]) && !dup;
      if (!valid && ok) begin
        valid  = 1'b1;
        type_o = c;
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Per-frame entity spawn/retire scheduler over a circular slot queue.
// In: clk, rst_n, start/crash/clear/tick/enable, speed, rng, min_speed,
// slot_visible/remove/x/width/gap. Out: slot_start/type/update,
// front, count, full, empty, busy, lead_idx.
module spawn_scheduler
  import spawn_scheduler_pkg::*;
#(
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  N_TYPES  = 3,
  parameter int  MAX_DUP  = 2,
  parameter int  VIEW_W   = DEF_VIEW_W,
  parameter int  RNG_GATE = 0,
  localparam int TYPE_W   = $clog2(N_TYPES + 1),
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         crash,
  input  logic                         clear,
  input  logic                         tick,
  input  logic                         enable,
  input  logic [14:0]                  speed,
  input  logic [10:0]                  rng,
  input  logic [N_TYPES:1][14:0]       min_speed,
  input  logic [DEPTH-1:0]             slot_visible,
  input  logic [DEPTH-1:0]             slot_remove,
  input  logic [DEPTH-1:0][10:0]       slot_x,
  input  logic [DEPTH-1:0][9:0]        slot_width,
  input  logic [DEPTH-1:0][10:0]       slot_gap,
  output logic [DEPTH-1:0]             slot_start,
  output logic [DEPTH-1:0][TYPE_W-1:0] slot_type,
  output logic                         slot_update,
  output logic [PW-1:0]                front,
  output logic [CW-1:0]                count,
  output logic                         full,
  output logic                         empty,
  output logic                         busy,
  output logic [PW-1:0]                lead_idx
);

  state_e                     state_q, state_d;
  logic [DEPTH-1:0]           start_q, start_d;
  logic [DEPTH-1:0][TYPE_W-1:0] type_q, type_d;
  logic [PW-1:0]              front_q, front_d;
  logic [PW-1:0]              back_q, back_d;
  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              lead_q;

  logic [PW-1:0]              last;
  logic [PW-1:0]              back_nx;
  logic [PW-1:0]              front_nx;
  logic signed [12:0]         sum;
  logic                       room;
  logic                       gate;
  logic                       can_spawn;
  logic [MAX_DUP-1:0][TYPE_W-1:0] recent;
  logic                       dup_chk;
  logic                       pick_valid;
  logic [TYPE_W-1:0]          pick_type;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign last     = (back_q == '0) ? PW'(DEPTH - 1)
                                   : back_q - PW'(1);
  assign back_nx  = (back_q == PW'(DEPTH - 1)) ? '0
                                               : back_q + PW'(1);
  assign front_nx = (front_q == PW'(DEPTH - 1)) ? '0
                                                : front_q + PW'(1);

  // 13-bit signed sum cannot wrap: |x|<=1024, w<=1023, gap<=2047
  assign sum  = 13'(signed'(slot_x[last]))
              + 13'(slot_width[last])
              + 13'(slot_gap[last]);
  assign room = sum < $signed(13'(VIEW_W));
  assign gate = (RNG_GATE == 0) || rng[0];

  always_comb begin
    recent = '0;
    for (int k = 0; k < MAX_DUP; k++) begin
      recent[k] = type_q[PW'((32'(back_q) + DEPTH - 1 - k) % DEPTH)];
    end
  end

  assign dup_chk = (count_q >= CW'(MAX_DUP));

  spawn_type_picker #(
    .N_TYPES (N_TYPES),
    .MAX_DUP (MAX_DUP)
  ) u_pick (
    .rng       (rng),
    .speed     (speed),
    .min_speed (min_speed),
    .recent    (recent),
    .dup_chk   (dup_chk),
    .valid     (pick_valid),
    .type_o    (pick_type)
  );

  assign can_spawn = pick_valid && enable
                  && (empty || (!full && slot_visible[last]
                                && room && gate));

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    type_d  = type_q;
    front_d = front_q;
    back_d  = back_q;
    count_d = count_q;
    if (clear) begin
      state_d = S_IDLE;
      start_d = '0;
      type_d  = '0;
      front_d = '0;
      back_d  = '0;
      count_d = '0;
    end else if (crash && state_q != S_IDLE) begin
      state_d = S_HALT;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_RUN;
        S_RUN:  if (tick) state_d = S_SPAWN;
        S_SPAWN: begin
          state_d = S_UPDATE;
          if (can_spawn) begin
            start_d[back_q] = 1'b1;
            type_d[back_q]  = pick_type;
            back_d          = back_nx;
            count_d         = count_q + CW'(1);
          end
        end
        S_UPDATE: state_d = S_SETTLE;
        S_SETTLE: state_d = S_RETIRE;
        S_RETIRE: begin
          // one retirement per cycle; stay until front is kept
          if (!empty && slot_remove[front_q]) begin
            start_d[front_q] = 1'b0;
            front_d          = front_nx;
            count_d          = count_q - CW'(1);
          end else begin
            state_d = S_RUN;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= '0;
      type_q  <= '0;
      front_q <= '0;
      back_q  <= '0;
      count_q <= '0;
      lead_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      type_q  <= type_d;
      front_q <= front_d;
      back_q  <= back_d;
      count_q <= count_d;
      lead_q  <= front_q;
    end
  end

  assign slot_start  = start_q;
  assign slot_type   = type_q;
  assign slot_update = (state_q == S_UPDATE);
  assign busy        = (state_q == S_SPAWN)  || (state_q == S_UPDATE)
                    || (state_q == S_SETTLE) || (state_q == S_RETIRE);
  assign front       = front_q;
  assign count       = count_q;
  assign lead_idx    = lead_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler (DEPTH=8, N_TYPES=3, MAX_DUP=2).
module tb_spawn_scheduler;

  localparam int DEPTH = 8;
  localparam int NT    = 3;

  logic clk = 1'b0;
  logic rst_n, start, crash, clear, tick, enable;
  logic [14:0] speed;
  logic [10:0] rng;
  logic [NT:1][14:0] min_speed;
  logic [DEPTH-1:0] slot_visible, slot_remove;
  logic [DEPTH-1:0][10:0] slot_x;
  logic [DEPTH-1:0][9:0] slot_width;
  logic [DEPTH-1:0][10:0] slot_gap;
  logic [DEPTH-1:0] slot_start;
  logic [DEPTH-1:0][1:0] slot_type;
  logic slot_update;
  logic [2:0] front, lead_idx;
  logic [3:0] count;
  logic full, empty, busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int rc;
  int p0;

  always #5 clk = ~clk;

  always @(negedge clk) if (slot_update === 1'b1) pulses++;

  spawn_scheduler #(
    .DEPTH(DEPTH), .N_TYPES(NT), .MAX_DUP(2),
    .VIEW_W(640), .RNG_GATE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .crash(crash),
    .clear(clear), .tick(tick), .enable(enable), .speed(speed),
    .rng(rng), .min_speed(min_speed),
    .slot_visible(slot_visible), .slot_remove(slot_remove),
    .slot_x(slot_x), .slot_width(slot_width), .slot_gap(slot_gap),
    .slot_start(slot_start), .slot_type(slot_type),
    .slot_update(slot_update), .front(front), .count(count),
    .full(full), .empty(empty), .busy(busy), .lead_idx(lead_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic geom(input int x);
    for (int k = 0; k < DEPTH; k++) begin
      slot_x[k]     = 11'(x);
      slot_width[k] = 10'd50;
      slot_gap[k]   = 11'd100;
    end
  endtask

  // tick from RUN, walk SPAWN/UPDATE/SETTLE, then wait out RETIRE
  task automatic frame(output int n);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    cyc();
    n = 0;
    while (busy && n < 20) begin
      n++;
      cyc();
    end
    chk("frame_bound", 32'(n < 20), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; crash = 1'b0; clear = 1'b0;
    tick = 1'b0; enable = 1'b0; speed = '0; rng = '0;
    min_speed = '0; slot_visible = '0; slot_remove = '0;
    slot_x = '0; slot_width = '0; slot_gap = '0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_start", 32'(slot_start), 32'd0);
    chk("rst_upd", 32'(slot_update), 32'd0);
    chk("rst_lead", 32'(lead_idx), 32'd0);
    rst_n = 1'b1;

    // first spawn into empty queue: rng=5 -> type 3 in slot 0
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'd0);
    enable = 1'b1; rng = 11'd5; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("spawn_busy", 32'(busy), 32'd1);
    chk("spawn_upd", 32'(slot_update), 32'd0);
    p0 = pulses;
    cyc();
    chk("upd_pulse", 32'(slot_update), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_start", 32'(slot_start), 32'h01);
    chk("t1_type0", 32'(slot_type[0]), 32'd3);
    cyc();
    chk("settle_upd", 32'(slot_update), 32'd0);
    cyc();
    chk("retire_busy", 32'(busy), 32'd1);
    cyc();
    chk("back_run", 32'(busy), 32'd0);
    chk("pulse_cnt", 32'(pulses - p0), 32'd1);

    // horizontal room rule on last slot
    slot_visible = '1;
    rng = 11'd4;
    geom(500);
    frame(rc);
    chk("room650", 32'(count), 32'd1);
    geom(490);
    frame(rc);
    chk("room640", 32'(count), 32'd1);
    geom(480);
    frame(rc);
    chk("room630", 32'(count), 32'd2);
    chk("t2_type1", 32'(slot_type[1]), 32'd2);

    // run-length limit: two 2s then rng favouring 2 gives 3
    frame(rc);
    chk("t3_type2", 32'(slot_type[2]), 32'd2);
    frame(rc);
    chk("t3_type3", 32'(slot_type[3]), 32'd3);
    chk("t3_count", 32'(count), 32'd4);

    // too slow for every type -> nothing spawns
    speed = 15'd50;
    min_speed = {15'd100, 15'd100, 15'd100};
    frame(rc);
    chk("slow_count", 32'(count), 32'd4);
    chk("slow_start", 32'(slot_start), 32'h0F);
    min_speed = '0;

    // fill to DEPTH with rng=0
    rng = 11'd0;
    for (int i = 0; i < 4; i++) frame(rc);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_start", 32'(slot_start), 32'hFF);
    chk("fill_type4", 32'(slot_type[4]), 32'd1);
    chk("fill_type6", 32'(slot_type[6]), 32'd2);
    frame(rc);
    chk("full_count", 32'(count), 32'd8);
    chk("full_front", 32'(front), 32'd0);

    // retire three front slots in one frame
    slot_remove = 8'h07;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    cyc();
    rc = 0;
    while (busy && rc < 20) begin
      if (rc == 1) begin
        chk("mid_front", 32'(front), 32'd1);
        chk("mid_lead", 32'(lead_idx), 32'd0);
      end
      rc++;
      cyc();
    end
    slot_remove = '0;
    chk("retire_len", 32'(rc), 32'd4);
    chk("ret_count", 32'(count), 32'd5);
    chk("ret_front", 32'(front), 32'd3);
    chk("ret_start", 32'(slot_start), 32'hF8);
    chk("ret_lead", 32'(lead_idx), 32'd3);

    // crash beats tick -> HALT, nothing moves
    p0 = pulses;
    crash = 1'b1; tick = 1'b1;
    cyc();
    crash = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    tick = 1'b0;
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pulse", 32'(pulses - p0), 32'd0);
    chk("halt_count", 32'(count), 32'd5);
    chk("halt_start", 32'(slot_start), 32'hF8);

    // clear flushes to IDLE; IDLE ignores tick
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_start", 32'(slot_start), 32'd0);
    chk("clr_type", 32'(slot_type), 32'd0);
    chk("clr_front", 32'(front), 32'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);

    // async reset landing while in RETIRE
    start = 1'b1;
    cyc();
    start = 1'b0;
    frame(rc);
    chk("r_count1", 32'(count), 32'd1);
    slot_remove = 8'h01;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("in_retire", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_start", 32'(slot_start), 32'd0);
    chk("ar_type", 32'(slot_type), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_front", 32'(front), 32'd0);
    chk("ar_lead", 32'(lead_idx), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    slot_remove = '0;
    cyc();
    rst_n = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("resume_busy", 32'(busy), 32'd1);
    cyc();
    chk("resume_cnt", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
